// File: rtl/qea_host_sequencer.sv
// Host-side job sequencer for the QEA core: loads gate contexts, seeds the |0..0> state,
// starts the core, times the run and streams the final state-RAM rows back out.
module qea_host_sequencer #(
    parameter int PE_NUM_WIDTH            = 2,
    parameter int PE_NUM                  = 4,
    parameter int DATA_WIDTH              = 32,
    parameter int NUM_FRAC_BIT            = 30,
    parameter int MAX_QBIT_WIDTH          = 6,
    parameter int STATE_ADDR_WIDTH        = 16,
    parameter int GATE_CONTEXT_ADDR_WIDTH = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_cmd_valid,
    output logic                               o_cmd_ready,
    input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] i_cmd_ins_num,
    input  logic [MAX_QBIT_WIDTH-1:0]          i_cmd_qbit_num,
    input  logic                               i_ctx_valid,
    output logic                               o_ctx_ready,
    input  logic [2*DATA_WIDTH-1:0]            i_ctx_data,
    output logic                               o_ctx_en,
    output logic                               o_ctx_wea,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0] o_ctx_addr,
    output logic [2*DATA_WIDTH-1:0]            o_ctx_data,
    output logic                               o_state_ena,
    output logic                               o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]        o_state_addra,
    output logic [PE_NUM*2*DATA_WIDTH-1:0]     o_state_dina,
    input  logic [PE_NUM*2*DATA_WIDTH-1:0]     i_state_dout,
    output logic [MAX_QBIT_WIDTH-1:0]          o_qbit_num,
    output logic                               o_start,
    input  logic                               i_complete,
    output logic                               o_rd_valid,
    input  logic                               i_rd_ready,
    output logic [PE_NUM*2*DATA_WIDTH-1:0]     o_rd_data,
    output logic                               o_rd_last,
    output logic                               o_busy,
    output logic [31:0]                        o_exec_cycles
);

    localparam int CTX_W = 2*DATA_WIDTH;
    localparam int ROW_W = PE_NUM*CTX_W;
    localparam logic [DATA_WIDTH-1:0]     AMP_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << NUM_FRAC_BIT;
    localparam logic [MAX_QBIT_WIDTH-1:0] PEW_Q   = MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
    localparam logic [MAX_QBIT_WIDTH-1:0] SAW_Q   = MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_CTX, S_INIT_STATE, S_START, S_RUN, S_RD_ADDR, S_RD_WAIT, S_RD_OUT
    } state_t;

    state_t                               r_state;
    logic                                 r_cmd_ready;
    logic                                 r_busy;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   r_ins_num;
    logic [MAX_QBIT_WIDTH-1:0]            r_qbit_num;
    logic [STATE_ADDR_WIDTH-1:0]          r_last_row;
    logic                                 r_ctx_ready;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   r_ctx_addr;
    logic                                 r_state_ena;
    logic                                 r_state_wea;
    logic [STATE_ADDR_WIDTH-1:0]          r_state_addra;
    logic [ROW_W-1:0]                     r_state_dina;
    logic                                 r_start;
    logic [31:0]                          r_exec_cycles;
    logic                                 r_rd_valid;
    logic [ROW_W-1:0]                     r_rd_data;
    logic                                 r_rd_last;

    logic                                 w_ctx_fire;
    logic [MAX_QBIT_WIDTH-1:0]            w_shift;
    logic [STATE_ADDR_WIDTH-1:0]          w_last_row;
    logic [ROW_W-1:0]                     w_row0;

    // Row 0 of the initial state: amplitude 1.0 + 0i in the most significant PE slot.
    genvar gi;
    generate
        for (gi = 0; gi < PE_NUM; gi++) begin : g_row0
            if (gi == PE_NUM-1) begin : g_top
                assign w_row0[gi*CTX_W +: CTX_W] = {AMP_ONE, {DATA_WIDTH{1'b0}}};
            end else begin : g_zero
                assign w_row0[gi*CTX_W +: CTX_W] = '0;
            end
        end
    endgenerate

    // ROWS-1 for the incoming command; saturates when the row count exceeds the address space.
    always_comb begin
        w_shift    = '0;
        w_last_row = '0;
        if (i_cmd_qbit_num > PEW_Q) begin
            w_shift = i_cmd_qbit_num - PEW_Q;
            if (w_shift >= SAW_Q) begin
                w_last_row = '1;
            end else begin
                w_last_row = STATE_ADDR_WIDTH'((32'd1 << w_shift) - 32'd1);
            end
        end
    end

    assign w_ctx_fire = r_ctx_ready & i_ctx_valid;

    // Context writes go straight through in the handshake cycle.
    assign o_ctx_en   = w_ctx_fire;
    assign o_ctx_wea  = w_ctx_fire;
    assign o_ctx_addr = r_ctx_addr;
    assign o_ctx_data = w_ctx_fire ? i_ctx_data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cmd_ready   <= 1'b1;
            r_busy        <= 1'b0;
            r_ins_num     <= '0;
            r_qbit_num    <= '0;
            r_last_row    <= '0;
            r_ctx_ready   <= 1'b0;
            r_ctx_addr    <= '0;
            r_state_ena   <= 1'b0;
            r_state_wea   <= 1'b0;
            r_state_addra <= '0;
            r_state_dina  <= '0;
            r_start       <= 1'b0;
            r_exec_cycles <= '0;
            r_rd_valid    <= 1'b0;
            r_rd_data     <= '0;
            r_rd_last     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_cmd_valid) begin
                        r_ins_num     <= i_cmd_ins_num;
                        r_qbit_num    <= i_cmd_qbit_num;
                        r_last_row    <= w_last_row;
                        r_exec_cycles <= '0;
                        r_ctx_addr    <= '0;
                        r_cmd_ready   <= 1'b0;
                        r_busy        <= 1'b1;
                        if (i_cmd_ins_num == '0) begin
                            r_state       <= S_INIT_STATE;
                            r_state_ena   <= 1'b1;
                            r_state_wea   <= 1'b1;
                            r_state_addra <= '0;
                            r_state_dina  <= w_row0;
                        end else begin
                            r_state     <= S_LOAD_CTX;
                            r_ctx_ready <= 1'b1;
                        end
                    end
                end
                S_LOAD_CTX: begin
                    if (w_ctx_fire) begin
                        if (r_ctx_addr == r_ins_num - GATE_CONTEXT_ADDR_WIDTH'(1)) begin
                            r_ctx_ready   <= 1'b0;
                            r_state       <= S_INIT_STATE;
                            r_state_ena   <= 1'b1;
                            r_state_wea   <= 1'b1;
                            r_state_addra <= '0;
                            r_state_dina  <= w_row0;
                        end else begin
                            r_ctx_addr <= r_ctx_addr + GATE_CONTEXT_ADDR_WIDTH'(1);
                        end
                    end
                end
                S_INIT_STATE: begin
                    r_state_dina <= '0;
                    if (r_state_addra == r_last_row) begin
                        r_state_ena   <= 1'b0;
                        r_state_wea   <= 1'b0;
                        r_state_addra <= '0;
                        r_start       <= 1'b1;
                        r_state       <= S_START;
                    end else begin
                        r_state_addra <= r_state_addra + STATE_ADDR_WIDTH'(1);
                    end
                end
                S_START: begin
                    r_start <= 1'b0;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    // The cycle that sees i_complete is deliberately not counted.
                    if (i_complete) begin
                        r_state_ena   <= 1'b1;
                        r_state_wea   <= 1'b0;
                        r_state_addra <= '0;
                        r_state       <= S_RD_ADDR;
                    end else if (r_exec_cycles != 32'hFFFF_FFFF) begin
                        r_exec_cycles <= r_exec_cycles + 32'd1;
                    end
                end
                S_RD_ADDR: begin
                    r_state_ena <= 1'b0;
                    r_state     <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    r_rd_data  <= i_state_dout;
                    r_rd_valid <= 1'b1;
                    r_rd_last  <= (r_state_addra == r_last_row);
                    r_state    <= S_RD_OUT;
                end
                S_RD_OUT: begin
                    if (i_rd_ready) begin
                        r_rd_valid <= 1'b0;
                        r_rd_last  <= 1'b0;
                        if (r_rd_last) begin
                            r_state_addra <= '0;
                            r_cmd_ready   <= 1'b1;
                            r_busy        <= 1'b0;
                            r_state       <= S_IDLE;
                        end else begin
                            r_state_addra <= r_state_addra + STATE_ADDR_WIDTH'(1);
                            r_state_ena   <= 1'b1;
                            r_state       <= S_RD_ADDR;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_cmd_ready   = r_cmd_ready;
    assign o_ctx_ready   = r_ctx_ready;
    assign o_state_ena   = r_state_ena;
    assign o_state_wea   = r_state_wea;
    assign o_state_addra = r_state_addra;
    assign o_state_dina  = r_state_dina;
    assign o_qbit_num    = r_qbit_num;
    assign o_start       = r_start;
    assign o_rd_valid    = r_rd_valid;
    assign o_rd_data     = r_rd_data;
    assign o_rd_last     = r_rd_last;
    assign o_busy        = r_busy;
    assign o_exec_cycles = r_exec_cycles;

endmodule

// File: tb/tb_qea_host_sequencer.sv
// Directed bench for qea_host_sequencer with a state-RAM model, a core model and a readout sink.
module tb_qea_host_sequencer;

    localparam logic [255:0] ROW0 = {64'h40000000_00000000, 192'h0};

    logic         clk = 1'b0;
    logic         rst;
    logic         i_cmd_valid;
    logic         o_cmd_ready;
    logic [15:0]  i_cmd_ins_num;
    logic [5:0]   i_cmd_qbit_num;
    logic         i_ctx_valid;
    logic         o_ctx_ready;
    logic [63:0]  i_ctx_data;
    logic         o_ctx_en, o_ctx_wea;
    logic [15:0]  o_ctx_addr;
    logic [63:0]  o_ctx_data;
    logic         o_state_ena, o_state_wea;
    logic [15:0]  o_state_addra;
    logic [255:0] o_state_dina;
    logic [255:0] state_dout;
    logic [5:0]   o_qbit_num;
    logic         o_start;
    logic         i_complete;
    logic         o_rd_valid;
    logic         i_rd_ready;
    logic [255:0] o_rd_data;
    logic         o_rd_last;
    logic         o_busy;
    logic [31:0]  o_exec_cycles;

    int tests_run = 0;
    int tests_failed = 0;

    qea_host_sequencer dut (
        .clk(clk), .rst(rst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_ins_num(i_cmd_ins_num), .i_cmd_qbit_num(i_cmd_qbit_num),
        .i_ctx_valid(i_ctx_valid), .o_ctx_ready(o_ctx_ready), .i_ctx_data(i_ctx_data),
        .o_ctx_en(o_ctx_en), .o_ctx_wea(o_ctx_wea), .o_ctx_addr(o_ctx_addr), .o_ctx_data(o_ctx_data),
        .o_state_ena(o_state_ena), .o_state_wea(o_state_wea), .o_state_addra(o_state_addra),
        .o_state_dina(o_state_dina), .i_state_dout(state_dout),
        .o_qbit_num(o_qbit_num), .o_start(o_start), .i_complete(i_complete),
        .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready), .o_rd_data(o_rd_data), .o_rd_last(o_rd_last),
        .o_busy(o_busy), .o_exec_cycles(o_exec_cycles)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ctx_word(input int k);
        return {32'hC0DE0000 ^ 32'(k), 32'(k * 7 + 3)};
    endfunction

    // Stand-in for the core's result: every row and slot distinct.
    function automatic logic [255:0] pat(input int r);
        logic [255:0] p;
        for (int s = 0; s < 8; s++) p[s*32 +: 32] = 32'h5A5A0000 ^ 32'(r * 256 + s);
        return p;
    endfunction

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // State RAM model, 1-cycle read latency; the core overwrites it with pat() when started.
    logic [255:0] mem [0:63];
    always @(posedge clk) begin
        if (o_start) begin
            for (int r = 0; r < 64; r++) mem[r] <= pat(r);
        end else if (o_state_ena) begin
            if (o_state_wea) mem[o_state_addra[5:0]] <= o_state_dina;
            else state_dout <= mem[o_state_addra[5:0]];
        end
    end

    // Settings owned by the main sequence
    int core_delay = 0;
    bit rd_rand = 1'b0;

    // Monitor state, cleared at reset and when a new job starts
    int ctx_seen, ctx_err, init_seen, init_err, ram_wr_after, starts, stall_err, core_cnt;
    bit started, core_armed, stalled, busy_q, ready_bit, held_last;
    logic [255:0] held_data;
    logic [255:0] rd_q[$];
    bit rd_last_q[$];

    always @(negedge clk) begin
        if (rst || (o_busy && !busy_q)) begin
            ctx_seen = 0; ctx_err = 0; init_seen = 0; init_err = 0; ram_wr_after = 0;
            starts = 0; stall_err = 0; core_cnt = 0; started = 0; core_armed = 0;
            stalled = 0; i_complete = 1'b0;
            rd_q.delete(); rd_last_q.delete();
        end
        busy_q = o_busy;
        if (o_ctx_en || o_ctx_wea) begin
            if (!(o_ctx_en && o_ctx_wea && i_ctx_valid && o_ctx_ready) ||
                o_ctx_addr != 16'(ctx_seen) || o_ctx_data != ctx_word(ctx_seen)) ctx_err++;
            ctx_seen++;
        end
        if (o_state_ena && o_state_wea) begin
            if (started) ram_wr_after++;
            else begin
                if (o_state_addra != 16'(init_seen) || o_state_dina != ((init_seen == 0) ? ROW0 : 256'h0))
                    init_err++;
                init_seen++;
            end
        end
        if (o_start) begin
            starts++; started = 1; core_armed = 1; core_cnt = core_delay;
        end else if (core_armed && !i_complete) begin
            if (core_cnt == 0) i_complete = 1'b1;
            else core_cnt--;
        end
        if (o_cmd_ready) begin
            i_complete = 1'b0; core_armed = 0;
        end
        if (o_rd_valid) begin
            if (stalled && (o_rd_data != held_data || o_rd_last != held_last)) stall_err++;
            ready_bit = rd_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            i_rd_ready = ready_bit;
            if (ready_bit) begin
                rd_q.push_back(o_rd_data); rd_last_q.push_back(o_rd_last); stalled = 0;
            end else begin
                stalled = 1; held_data = o_rd_data; held_last = o_rd_last;
            end
        end else begin
            if (stalled) stall_err++;
            stalled = 0;
            i_rd_ready = rd_rand ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    task automatic send_cmd(input logic [15:0] ins, input logic [5:0] q);
        i_cmd_valid = 1'b1; i_cmd_ins_num = ins; i_cmd_qbit_num = q;
        @(negedge clk);
        i_cmd_valid = 1'b0;
    endtask

    task automatic stream_ctx(input int n, input bit gaps);
        int k = 0;
        int guard = 0;
        while (k < n && guard < 5000) begin
            i_ctx_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            i_ctx_data = ctx_word(k);
            if (i_ctx_valid && o_ctx_ready) k++;
            @(negedge clk);
            guard++;
        end
        i_ctx_valid = 1'b0;
        check("ctx_words_accepted", 256'(k), 256'(n));
    endtask

    task automatic wait_idle();
        int g = 0;
        while (!o_cmd_ready && g < 3000) begin
            @(negedge clk);
            g++;
        end
        check("job_done", 256'(o_cmd_ready), 256'(1));
    endtask

    function automatic logic [15:0] last_mask();
        logic [15:0] m = '0;
        foreach (rd_last_q[i]) if (rd_last_q[i] && i < 16) m[i] = 1'b1;
        return m;
    endfunction

    initial begin
        rst = 1'b1; i_cmd_valid = 1'b0; i_cmd_ins_num = '0; i_cmd_qbit_num = '0;
        i_ctx_valid = 1'b0; i_ctx_data = '0; i_complete = 1'b0; i_rd_ready = 1'b0;
        state_dout = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 256'(o_cmd_ready), 256'(1));
        check("rst_busy", 256'(o_busy), 256'(0));
        check("rst_ctx_ready", 256'(o_ctx_ready), 256'(0));
        check("rst_state_ena", 256'(o_state_ena), 256'(0));
        check("rst_start", 256'(o_start), 256'(0));
        check("rst_rd_valid", 256'(o_rd_valid), 256'(0));
        check("rst_exec_cycles", 256'(o_exec_cycles), 256'(0));
        rst = 1'b0;
        @(negedge clk);

        // Reset while word 3 of 10 is being offered
        send_cmd(16'd10, 6'd6);
        check("t1_busy", 256'(o_busy), 256'(1));
        check("t1_ctx_ready", 256'(o_ctx_ready), 256'(1));
        stream_ctx(3, 1'b0);
        check("t1_ctx_addr_before", 256'(o_ctx_addr), 256'(3));
        i_ctx_valid = 1'b1; i_ctx_data = ctx_word(3); rst = 1'b1;
        @(negedge clk);
        check("t1_ctx_en", 256'(o_ctx_en), 256'(0));
        check("t1_ctx_wea", 256'(o_ctx_wea), 256'(0));
        check("t1_state_ena", 256'(o_state_ena), 256'(0));
        check("t1_cmd_ready", 256'(o_cmd_ready), 256'(1));
        check("t1_ctx_addr", 256'(o_ctx_addr), 256'(0));
        rst = 1'b0; i_ctx_valid = 1'b0;
        @(negedge clk);

        // 601 words with gaps, 16 rows, core done after 50 cycles, stalled readout
        core_delay = 50; rd_rand = 1'b1;
        send_cmd(16'd601, 6'd6);
        check("t2_qbit_num", 256'(o_qbit_num), 256'(6));
        stream_ctx(601, 1'b1);
        wait_idle();
        check("t2_ctx_strobes", 256'(ctx_seen), 256'(601));
        check("t2_ctx_errors", 256'(ctx_err), 256'(0));
        check("t3_init_rows", 256'(init_seen), 256'(16));
        check("t3_init_errors", 256'(init_err), 256'(0));
        check("t3_start_pulses", 256'(starts), 256'(1));
        check("t4_exec_cycles", 256'(o_exec_cycles), 256'(50));
        check("t4_rd_rows", 256'(rd_q.size()), 256'(16));
        for (int i = 0; i < 16 && i < rd_q.size(); i++) check($sformatf("t4_rd_row%0d", i), rd_q[i], pat(i));
        check("t4_rd_last_mask", 256'(last_mask()), 256'(16'h8000));
        check("t5_stall_errors", 256'(stall_err), 256'(0));
        check("t5_readout_writes", 256'(ram_wr_after), 256'(0));
        check("t5_busy_after", 256'(o_busy), 256'(0));
        repeat (4) @(negedge clk);
        check("t5_exec_held", 256'(o_exec_cycles), 256'(50));

        // ins_num=0, qbit_num=2: single row, complete immediately
        core_delay = 0; rd_rand = 1'b0;
        send_cmd(16'd0, 6'd2);
        check("t6_ctx_ready", 256'(o_ctx_ready), 256'(0));
        wait_idle();
        check("t6_ctx_strobes", 256'(ctx_seen), 256'(0));
        check("t6_init_rows", 256'(init_seen), 256'(1));
        check("t6_init_errors", 256'(init_err), 256'(0));
        check("t6_start_pulses", 256'(starts), 256'(1));
        check("t6_exec_cycles", 256'(o_exec_cycles), 256'(0));
        check("t6_rd_rows", 256'(rd_q.size()), 256'(1));
        if (rd_q.size() > 0) check("t6_rd_row0", rd_q[0], pat(0));
        check("t6_rd_last_mask", 256'(last_mask()), 256'(16'h0001));
        check("t6_busy_after", 256'(o_busy), 256'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
